branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped BTB/BHT entries (power of two, 4..64).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 StallF  in  1  fetch stage stalled.
REQ-005 StallE  in  1  execute stage stalled.
REQ-006 PCF  in  32  fetch-stage PC, lookup address.
REQ-007 PCE  in  32  PC of instruction in execute.
REQ-008 BranchE  in  1  instruction in execute is a conditional branch.
REQ-009 TakenE  in  1  resolved branch outcome in execute.
REQ-010 BranchTargetE  in  32  resolved branch target in execute.
REQ-011 PredTakenE  in  1  prediction that was made for the instruction now in execute (PredTakenF piped through D).
REQ-012 PCSrc  out  2  PC select: 00 sequential, 01 TargetAddr, 10 recover to PCNextE.
REQ-013 TargetAddr  out  32  redirect address for PCSrc=01.
REQ-014 PredTakenF  out  1  prediction for the instruction at PCF, carried down the pipeline.
REQ-015 FlushD  out  1  kill decode-stage instruction.
REQ-016 FlushE  out  1  kill instruction entering execute.
REQ-017 BranchCount  out  16  resolved conditional branches, saturating.
REQ-018 MispredictCount  out  16  mispredictions, saturating.

Function
REQ-019 Each entry SHALL hold valid, tag = PC[31:2+log2(ENTRIES)], target[31:0], 2-bit saturating counter; index = PC[1+log2(ENTRIES):2].
REQ-020 Fetch hit SHALL be: entry[PCF index] valid AND tag matches PCF AND counter[1]=1; lookup is combinational, zero-cycle latency.
REQ-021 PredTakenF SHALL equal fetch hit AND NOT StallF AND NOT mispredict.
REQ-022 mispredict SHALL be NOT StallE AND ((BranchE AND TakenE != PredTakenE) OR (NOT BranchE AND PredTakenE)).
REQ-023 On mispredict with BranchE AND TakenE: PCSrc=01, TargetAddr=BranchTargetE.
REQ-024 On any other mispredict: PCSrc=10, TargetAddr=BranchTargetE (don't-care).
REQ-025 Without mispredict and with PredTakenF=1: PCSrc=01, TargetAddr=entry target.
REQ-026 Otherwise PCSrc=00, TargetAddr=BranchTargetE.
REQ-027 FlushD and FlushE SHALL equal mispredict; execute-stage correction SHALL always take priority over fetch prediction.
REQ-028 Update SHALL occur on rising edge when BranchE AND NOT StallE, at PCE index.
REQ-029 Update on tag hit: counter +1 if TakenE (saturate at 11), -1 if not (saturate at 00); target <= BranchTargetE.
REQ-030 Update on miss/invalid with TakenE: valid<=1, tag, target<=BranchTargetE, counter<=10 (overwrite any alias).
REQ-031 Update on miss with NOT TakenE: entry unchanged.
REQ-032 Same-index fetch lookup and update in one cycle: lookup SHALL use pre-update state (read-before-write).
REQ-033 BranchCount SHALL increment on each update cycle; MispredictCount on each mispredict cycle; both hold at 0xFFFF.

Reset
REQ-034 While reset=1 at a rising edge: all valid<=0, all counters<=01, BranchCount<=0, MispredictCount<=0.
REQ-035 While reset=1, outputs SHALL be forced: PCSrc=00, PredTakenF=0, FlushD=FlushE=0; no update occurs.
REQ-036 Reset asserted mid-operation SHALL discard all learned state within one cycle; first post-reset fetch SHALL predict not-taken.

Verification
REQ-037 Cold branch: reset, BranchE=1 TakenE=1 PredTakenE=0 PCE=0x40 BranchTargetE=0x100 -> PCSrc=01, TargetAddr=0x100, FlushD=FlushE=1, MispredictCount=1; next cycle PCF=0x40 -> PredTakenF=1, PCSrc=01, TargetAddr=0x100.
REQ-038 Predicted not-taken recovery: entry at 0x40 counter=10, resolve TakenE=0 PredTakenE=1 -> PCSrc=10, flushes=1, counter becomes 01, PCF=0x40 then predicts not-taken (PCSrc=00).
REQ-039 Saturation: four taken updates at 0x40 -> counter 11; one not-taken -> 10, still predicts taken.
REQ-040 Alias: ENTRIES=16, allocate 0x40 then taken branch at 0x80 (same index) -> PCF=0x40 misses, PCF=0x80 hits with new target.
REQ-041 Stalls/priority: mispredict with StallE=1 -> no flush, no update; simultaneous fetch hit and E mispredict -> E correction wins, PredTakenF=0.
REQ-042 Reset mid-run: trained entries, assert reset one cycle -> counters 0, PCF of trained branch -> PCSrc=00.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, fetch redirect and execute recovery
//
// Purpose:
//   Predicts conditional branches at fetch with a direct-mapped branch target
//   buffer. Each entry holds valid, tag, target and a 2-bit saturating counter.
//   Branches resolved in execute train the table. A wrong prediction makes
//   execute redirect fetch and flush decode and execute.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   StallF, StallE     fetch / execute stage stalls
//   PCF                fetch PC, used for the combinational lookup
//   PCE                execute PC, used as the update index and tag
//   BranchE, TakenE    execute holds a conditional branch, and its resolved outcome
//   BranchTargetE      resolved branch target
//   PredTakenE         prediction made earlier for the execute instruction
//   PCSrc              00 sequential, 01 TargetAddr, 10 recover to PCNextE
//   TargetAddr         redirect address used when PCSrc = 01
//   PredTakenF         fetch prediction, carried down the pipeline
//   FlushD, FlushE     kill decode / execute instructions on a mispredict
//   BranchCount        resolved conditional branches (saturating)
//   MispredictCount    mispredictions (saturating)

module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallE,
    input  logic [31:0] PCF,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic        TakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    output logic [1:0]  PCSrc,
    output logic [31:0] TargetAddr,
    output logic        PredTakenF,
    output logic        FlushD,
    output logic        FlushE,
    output logic [15:0] BranchCount,
    output logic [15:0] MispredictCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - 2 - IDX_W;

    localparam logic [1:0] SEL_SEQ     = 2'b00;
    localparam logic [1:0] SEL_TARGET  = 2'b01;
    localparam logic [1:0] SEL_RECOVER = 2'b10;

    // Table storage
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    // Address decomposition
    logic [IDX_W-1:0] fetch_idx, exec_idx;
    logic [TAG_W-1:0] fetch_tag, exec_tag;

    assign fetch_idx = PCF[IDX_W+1:2];
    assign fetch_tag = PCF[31:IDX_W+2];
    assign exec_idx  = PCE[IDX_W+1:2];
    assign exec_tag  = PCE[31:IDX_W+2];

    // Word-aligned PCs: the byte-offset bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    // Control signals
    logic fetch_hit;
    logic mispredict;
    logic update;
    logic exec_hit;

    always_comb begin
        // Lookup reads the registered table, so a same-cycle update to the
        // same index is seen only on the following cycle.
        fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag)
                    && ctr_q[fetch_idx][1];

        // Reset gates everything so no redirect, flush or training happens
        // while the table is being cleared.
        mispredict = !reset && !StallE &&
                     ((BranchE && (TakenE != PredTakenE)) || (!BranchE && PredTakenE));

        update   = !reset && BranchE && !StallE;
        exec_hit = valid_q[exec_idx] && (tag_q[exec_idx] == exec_tag);
    end

    // Outputs: execute correction always wins over a fetch prediction.
    always_comb begin
        PredTakenF = !reset && fetch_hit && !StallF && !mispredict;
        FlushD     = mispredict;
        FlushE     = mispredict;
        PCSrc      = SEL_SEQ;
        TargetAddr = BranchTargetE;

        if (mispredict) begin
            PCSrc = (BranchE && TakenE) ? SEL_TARGET : SEL_RECOVER;
        end else if (PredTakenF) begin
            PCSrc      = SEL_TARGET;
            TargetAddr = target_q[fetch_idx];
        end
    end

    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = mispred_cnt_q;

    // Table next state
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;

        if (update) begin
            if (exec_hit) begin
                if (TakenE) begin
                    if (ctr_q[exec_idx] != 2'b11) begin
                        ctr_d[exec_idx] = ctr_q[exec_idx] + 2'b01;
                    end
                end else begin
                    if (ctr_q[exec_idx] != 2'b00) begin
                        ctr_d[exec_idx] = ctr_q[exec_idx] - 2'b01;
                    end
                end
                target_d[exec_idx] = BranchTargetE;
            end else if (TakenE) begin
                // Allocate on a taken miss, evicting whatever alias lived here.
                // Starting weakly taken makes the next fetch predict taken.
                valid_d[exec_idx]  = 1'b1;
                tag_d[exec_idx]    = exec_tag;
                target_d[exec_idx] = BranchTargetE;
                ctr_d[exec_idx]    = 2'b10;
            end
            // Not-taken misses are not worth a table entry.
        end
    end

    // Statistics next state
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
        end
        if (mispredict && (mispred_cnt_q != 16'hFFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            branch_cnt_q  <= 16'd0;
            mispred_cnt_q <= 16'd0;
        end else begin
            valid_q       <= valid_d;
            ctr_q         <= ctr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Tag and target are qualified by valid, so they need no reset. Updates
    // are already blocked while reset is high.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        reset, StallF, StallE, BranchE, TakenE, PredTakenE;
    logic [31:0] PCF, PCE, BranchTargetE;
    logic [1:0]  PCSrc;
    logic [31:0] TargetAddr;
    logic        PredTakenF, FlushD, FlushE;
    logic [15:0] BranchCount, MispredictCount;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallE(StallE),
        .PCF(PCF), .PCE(PCE), .BranchE(BranchE), .TakenE(TakenE),
        .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE),
        .PCSrc(PCSrc), .TargetAddr(TargetAddr), .PredTakenF(PredTakenF),
        .FlushD(FlushD), .FlushE(FlushE),
        .BranchCount(BranchCount), .MispredictCount(MispredictCount)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model of the table (ENTRIES = 16: index PC[5:2], tag PC[31:6])
    bit          m_valid [ENTRIES];
    logic [25:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [1:0]  m_ctr   [ENTRIES];
    int          m_bc = 0;
    int          m_mc = 0;

    typedef struct {
        logic [1:0]  pcsrc;
        logic [31:0] taddr;
        logic        ptf;
        logic        flush;
        bit          chk_taddr;
    } exp_t;

    exp_t sb[$];

    task automatic cycle(input bit rst, input bit sf, input bit se, input bit br,
                         input bit tk, input bit pte, input logic [31:0] pcf,
                         input logic [31:0] pce, input logic [31:0] bt);
        exp_t e;
        exp_t o;
        int   fi, ei;
        bit   hit, mis, ehit;
        @(negedge clk);
        reset = rst; StallF = sf; StallE = se; BranchE = br; TakenE = tk;
        PredTakenE = pte; PCF = pcf; PCE = pce; BranchTargetE = bt;

        fi  = int'(pcf[5:2]);
        hit = m_valid[fi] && (m_tag[fi] == pcf[31:6]) && (m_ctr[fi] >= 2'b10);
        mis = !rst && !se && (br ? (tk != pte) : pte);
        e.flush     = mis;
        e.ptf       = !rst && hit && !sf && !mis;
        e.chk_taddr = 1'b0;
        e.pcsrc     = 2'b00;
        e.taddr     = bt;
        if (mis) begin
            e.pcsrc     = (br && tk) ? 2'b01 : 2'b10;
            e.chk_taddr = (br && tk);
        end else if (e.ptf) begin
            e.pcsrc     = 2'b01;
            e.taddr     = m_tgt[fi];
            e.chk_taddr = 1'b1;
        end else if (!rst) begin
            e.chk_taddr = 1'b1;
        end
        sb.push_back(e);

        #1;
        o = sb.pop_front();
        check_eq("PCSrc", 32'(PCSrc), 32'(o.pcsrc));
        check_eq("PredTakenF", 32'(PredTakenF), 32'(o.ptf));
        check_eq("FlushD", 32'(FlushD), 32'(o.flush));
        check_eq("FlushE", 32'(FlushE), 32'(o.flush));
        if (o.chk_taddr) check_eq("TargetAddr", TargetAddr, o.taddr);

        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 2'b01;
            end
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (mis && m_mc < 16'hFFFF) m_mc++;
            if (br && !se) begin
                if (m_bc < 16'hFFFF) m_bc++;
                ei   = int'(pce[5:2]);
                ehit = m_valid[ei] && (m_tag[ei] == pce[31:6]);
                if (ehit) begin
                    if (tk && m_ctr[ei] != 2'b11) m_ctr[ei] = m_ctr[ei] + 2'b01;
                    if (!tk && m_ctr[ei] != 2'b00) m_ctr[ei] = m_ctr[ei] - 2'b01;
                    m_tgt[ei] = bt;
                end else if (tk) begin
                    m_valid[ei] = 1'b1;
                    m_tag[ei]   = pce[31:6];
                    m_tgt[ei]   = bt;
                    m_ctr[ei]   = 2'b10;
                end
            end
        end
        #1;
        check_eq("BranchCount", 32'(BranchCount), 32'(m_bc));
        check_eq("MispredictCount", 32'(MispredictCount), 32'(m_mc));
    endtask

    // Idle cycle that only looks up a fetch PC.
    task automatic fetch(input logic [31:0] pcf);
        cycle(0, 0, 0, 0, 0, 0, pcf, 32'h0, 32'hDEAD_0000);
    endtask

    logic [31:0] pcs [6];

    initial begin
        reset = 1'b1; StallF = 1'b0; StallE = 1'b0; BranchE = 1'b0; TakenE = 1'b0;
        PredTakenE = 1'b0; PCF = 32'h0; PCE = 32'h0; BranchTargetE = 32'h0;
        pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'hC0;
        pcs[3] = 32'h1040; pcs[4] = 32'h44; pcs[5] = 32'h2084;

        cycle(1, 0, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0);
        cycle(1, 0, 0, 1, 1, 1, 32'h40, 32'h40, 32'h100);
        check_eq("reset_bc", 32'(BranchCount), 32'h0);

        // Cold branch, then the trained entry predicts taken
        cycle(0, 0, 0, 1, 1, 0, 32'h200, 32'h40, 32'h100);
        check_eq("cold_mc", 32'(MispredictCount), 32'h1);
        fetch(32'h40);
        check_eq("cold_hit_tgt", TargetAddr, 32'h100);

        // Predicted-taken but not taken: recover, counter 10 -> 01
        cycle(0, 0, 0, 1, 0, 1, 32'h300, 32'h40, 32'h100);
        fetch(32'h40);

        // Saturation: 4 taken -> 11, one not-taken -> 10, still taken
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, (i >= 1), 32'h300, 32'h40, 32'h100);
        cycle(0, 0, 0, 1, 0, 1, 32'h300, 32'h40, 32'h100);
        fetch(32'h40);
        check_eq("sat_still_taken", 32'(PCSrc), 32'h1);

        // Alias at index 0
        cycle(0, 0, 0, 1, 1, 0, 32'h300, 32'h80, 32'h380);
        fetch(32'h40);
        fetch(32'h80);

        // Stalled execute: no flush, no update
        cycle(0, 0, 1, 1, 1, 0, 32'h300, 32'h80, 32'h999);
        // Fetch hit and execute mispredict together: execute wins
        cycle(0, 0, 0, 1, 1, 0, 32'h80, 32'h400, 32'h500);
        // Stalled fetch suppresses prediction
        cycle(0, 1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h0);
        // Same-index lookup and update: lookup sees pre-update state
        cycle(0, 0, 0, 1, 0, 0, 32'h80, 32'h80, 32'h380);
        cycle(0, 0, 0, 1, 0, 0, 32'h80, 32'h80, 32'h380);
        fetch(32'h80);

        // Reset mid-run
        cycle(0, 0, 0, 1, 1, 0, 32'h300, 32'h80, 32'h380);
        cycle(1, 0, 0, 0, 0, 0, 32'h80, 32'h0, 32'h0);
        fetch(32'h80);
        check_eq("post_reset_pcsrc", 32'(PCSrc), 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0),
                  pcs[$urandom_range(0, 5)], pcs[$urandom_range(0, 5)],
                  32'h1000 + 32'($urandom_range(0, 15)) * 32'h10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
